// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory stage.
// Holds the stage FSM encoding, error codes and the datapath word width.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/mem_stage_bus_timer.sv
// bus_timer: counts cycles a bus request has been outstanding.
// Ports: i_clk, i_rst (sync, active-high), i_clr, i_en, o_expired.
module bus_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Counter holds completed request cycles; the cycle it reads
    // TIMEOUT-1 is the last one the request may stay high.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS data-memory stage; one load/store per instruction over a
// req/ack bus, then a one-cycle writeback record. Ports: execution-stage
// inputs (valid_in/ready_in, alu_result, store_data, wreg, control bits),
// data bus (mem_req/we/addr/wdata/rdata/ack), writeback (wb_*), err/err_code.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] store_data,
    input  logic [4:0]        wreg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_reg,
    output logic [WORD_W-1:0] wb_data,
    output logic              err,
    output logic [1:0]        err_code
);

    state_t            r_state;
    logic              r_ready;
    logic              r_memtoreg;
    logic              r_regwrite;
    logic [4:0]        r_wreg;
    logic [WORD_W-1:0] r_alu;

    logic              w_accept;
    logic              w_is_mem;
    logic [1:0]        w_code;
    logic              w_expired;

    assign w_accept = (r_state == S_IDLE) && valid_in;
    assign w_is_mem = MemRead || MemWrite;

    // Illegal takes precedence over misalignment; neither touches the bus.
    always_comb begin
        w_code = ERR_NONE;
        if (MemRead && MemWrite) begin
            w_code = ERR_ILLEGAL;
        end else if (w_is_mem && (alu_result[1:0] != 2'b00)) begin
            w_code = ERR_MISALIGN;
        end
    end

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (w_accept),
        .i_en      (r_state == S_ACCESS),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_alu      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    wb_valid <= 1'b0;
                    wb_we    <= 1'b0;
                    if (valid_in) begin
                        r_ready    <= 1'b0;
                        r_memtoreg <= MemtoReg;
                        r_regwrite <= RegWrite;
                        r_wreg     <= wreg;
                        r_alu      <= alu_result;
                        if (w_is_mem && (w_code == ERR_NONE)) begin
                            r_state   <= S_ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= alu_result[ADDR_W-1:0];
                            mem_wdata <= store_data;
                        end else begin
                            // No bus cycle: writeback straight away.
                            r_state  <= S_RESP;
                            wb_valid <= 1'b1;
                            wb_reg   <= wreg;
                            wb_data  <= MemtoReg ? '0 : alu_result;
                            wb_we    <= RegWrite && (wreg != '0) &&
                                        (w_code == ERR_NONE);
                            if (w_code != ERR_NONE) begin
                                err      <= 1'b1;
                                err_code <= w_code;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack wins over an expiry in the same cycle.
                    if (mem_ack) begin
                        r_state  <= S_RESP;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_reg   <= r_wreg;
                        wb_data  <= r_memtoreg ? mem_rdata : r_alu;
                        wb_we    <= r_regwrite && (r_wreg != '0);
                    end else if (w_expired) begin
                        r_state  <= S_RESP;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_reg   <= r_wreg;
                        wb_data  <= r_memtoreg ? '0 : r_alu;
                        wb_we    <= 1'b0;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b1;
                    wb_valid <= 1'b0;
                    wb_we    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    wb_valid <= 1'b0;
                    wb_we   <= 1'b0;
                end
            endcase
        end
    end

    assign ready_in = r_ready;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): passthrough, load, store,
// misalign, illegal, timeout, late ack and reset during an access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  wreg;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_code;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage #(
        .TIMEOUT (4),
        .ADDR_W  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .alu_result (alu_result),
        .store_data (store_data),
        .wreg       (wreg),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic mr,
                         input logic mw, input logic m2r, input logic rw);
        alu_result = a;
        store_data = sd;
        wreg       = r;
        MemRead    = mr;
        MemWrite   = mw;
        MemtoReg   = m2r;
        RegWrite   = rw;
        valid_in   = 1'b1;
        step();
        valid_in   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        valid_in = 0; alu_result = 0; store_data = 0; wreg = 0;
        MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        mem_rdata = 0; mem_ack = 0;
        #1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(ready_in), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbdata", wb_data, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);

        // ALU passthrough
        issue(32'h42, 32'h0, 5'd3, 0, 0, 0, 1);
        chk("pt_wbv", 32'(wb_valid), 32'd1);
        chk("pt_data", wb_data, 32'h42);
        chk("pt_we", 32'(wb_we), 32'd1);
        chk("pt_reg", 32'(wb_reg), 32'd3);
        chk("pt_req", 32'(mem_req), 32'd0);
        chk("pt_rdy0", 32'(ready_in), 32'd0);
        step();
        chk("pt_wbv_off", 32'(wb_valid), 32'd0);
        chk("pt_rdy1", 32'(ready_in), 32'd1);

        // Load, ack in third request cycle
        issue(32'h100, 32'h0, 5'd8, 1, 0, 1, 1);
        chk("ld_req1", 32'(mem_req), 32'd1);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_rdy", 32'(ready_in), 32'd0);
        step();
        chk("ld_req2", 32'(mem_req), 32'd1);
        chk("ld_wbv_wait", 32'(wb_valid), 32'd0);
        step();
        chk("ld_req3", 32'(mem_req), 32'd1);
        chk("ld_addr3", mem_addr, 32'h100);
        chk("ld_rdy3", 32'(ready_in), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 1'b0;
        chk("ld_req_off", 32'(mem_req), 32'd0);
        chk("ld_wbv", 32'(wb_valid), 32'd1);
        chk("ld_data", wb_data, 32'hDEADBEEF);
        chk("ld_reg", 32'(wb_reg), 32'd8);
        chk("ld_wbwe", 32'(wb_we), 32'd1);
        chk("ld_rdy_resp", 32'(ready_in), 32'd0);
        step();
        chk("ld_rdy_end", 32'(ready_in), 32'd1);

        // Store, same-cycle ack
        issue(32'h204, 32'h1234, 5'd0, 0, 1, 0, 0);
        mem_ack = 1'b1;
        chk("st_req", 32'(mem_req), 32'd1);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_wdata", mem_wdata, 32'h1234);
        chk("st_addr", mem_addr, 32'h204);
        step();
        mem_ack = 1'b0;
        chk("st_req_off", 32'(mem_req), 32'd0);
        chk("st_we_off", 32'(mem_we), 32'd0);
        chk("st_wbv", 32'(wb_valid), 32'd1);
        chk("st_wbwe", 32'(wb_we), 32'd0);
        step();

        // Misaligned load
        issue(32'h102, 32'h0, 5'd5, 1, 0, 1, 1);
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_wbv", 32'(wb_valid), 32'd1);
        chk("mis_wbwe", 32'(wb_we), 32'd0);
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_code", 32'(err_code), 32'd1);
        step();

        // Load to r0: no write, error state unchanged
        issue(32'h10, 32'h0, 5'd0, 1, 0, 1, 1);
        mem_ack = 1'b1;
        mem_rdata = 32'h55;
        step();
        mem_ack = 1'b0;
        chk("r0_wbv", 32'(wb_valid), 32'd1);
        chk("r0_wbwe", 32'(wb_we), 32'd0);
        chk("r0_data", wb_data, 32'h55);
        chk("r0_err", 32'(err), 32'd1);
        chk("r0_code", 32'(err_code), 32'd1);
        step();

        // Illegal read+write
        issue(32'h20, 32'h0, 5'd4, 1, 1, 0, 1);
        chk("ill_req", 32'(mem_req), 32'd0);
        chk("ill_wbwe", 32'(wb_we), 32'd0);
        chk("ill_code", 32'(err_code), 32'd2);
        step();

        // Timeout: request high exactly 4 cycles
        issue(32'h300, 32'h0, 5'd9, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
            chk($sformatf("to_wbv%0d", i), 32'(wb_valid), 32'd0);
            step();
        end
        chk("to_req_off", 32'(mem_req), 32'd0);
        chk("to_wbv", 32'(wb_valid), 32'd1);
        chk("to_wbwe", 32'(wb_we), 32'd0);
        chk("to_code", 32'(err_code), 32'd3);
        chk("to_err", 32'(err), 32'd1);
        step();

        // Late ack while idle is ignored
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF0000;
        step();
        mem_ack = 1'b0;
        chk("late_rdy", 32'(ready_in), 32'd1);
        chk("late_req", 32'(mem_req), 32'd0);
        chk("late_wbv", 32'(wb_valid), 32'd0);
        chk("late_code", 32'(err_code), 32'd3);

        // Reset during an access
        issue(32'h400, 32'h0, 5'd6, 1, 0, 1, 1);
        chk("ra_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ra_req_off", 32'(mem_req), 32'd0);
        chk("ra_wbv", 32'(wb_valid), 32'd0);
        chk("ra_err", 32'(err), 32'd0);
        chk("ra_code", 32'(err_code), 32'd0);
        chk("ra_rdy", 32'(ready_in), 32'd1);
        step();
        chk("ra_wbv2", 32'(wb_valid), 32'd0);

        issue(32'h404, 32'h0, 5'd7, 1, 0, 1, 1);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        chk("nx_addr", mem_addr, 32'h404);
        step();
        mem_ack = 1'b0;
        chk("nx_wbv", 32'(wb_valid), 32'd1);
        chk("nx_data", wb_data, 32'hCAFEF00D);
        chk("nx_reg", 32'(wb_reg), 32'd7);
        chk("nx_wbwe", 32'(wb_we), 32'd1);
        chk("nx_err", 32'(err), 32'd0);
        step();
        chk("nx_rdy", 32'(ready_in), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Data-memory stage of the MIPS datapath, placed directly downstream of the execution stage. It takes the ALU result, the store operand (RData2) and the memory/writeback control bits. It performs one load or store per instruction over a request/acknowledge data-memory bus, then presents a single-cycle writeback record (register, data, write enable) to the register file. It stalls upstream while a memory access is outstanding and flags misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT, 16: max cycles mem_req may wait for mem_ack before a bus error (≥1)
- ADDR_W, 32: data address width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  execution stage presents an instruction
- ready_in  out  1  stage can accept (high only in IDLE)
- alu_result  in  32  ALU output; memory address or passthrough data
- store_data  in  32  RData2, store operand
- wreg  in  5  destination register (RegDst-muxed)
- MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from control unit
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  access complete
- wb_valid  out  1  one-cycle writeback pulse
- wb_we  out  1  register file write enable
- wb_reg  out  5  destination register
- wb_data  out  32  writeback value
- err  out  1  sticky error, cleared only by rst
- err_code  out  2  0 none, 1 misaligned, 2 illegal (MemRead&MemWrite), 3 bus timeout

## Operation
- States: IDLE, ACCESS, RESP. Encoding lives in the shared package.
- IDLE: ready_in=1. On valid_in, all inputs are latched.
  - Neither MemRead nor MemWrite → RESP.
  - MemRead&MemWrite → RESP with err_code=2 and no bus activity.
  - alu_result[1:0]≠0 on a memory op → RESP with err_code=1 and no bus activity.
  - Otherwise → ACCESS.
- ACCESS: mem_req=1. mem_we=latched MemWrite. mem_addr, mem_wdata and mem_we stay stable until ack. On mem_ack: capture mem_rdata, drop mem_req, go to RESP. If the timer reaches TIMEOUT without ack: drop mem_req, set err_code=3, go to RESP.
- RESP: wb_valid=1 for exactly one cycle, then go to IDLE.
  - wb_data = MemtoReg ? captured rdata : latched alu_result.
  - wb_we = RegWrite & (wreg≠0) & no error on this instruction.
- err/err_code: a later error overwrites err_code; err stays 1.
- mem_ack outside ACCESS is ignored.

## Timing
- Reset values: state IDLE, ready_in 1, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, wb_valid 0, wb_we 0, wb_reg 0, wb_data 0, err 0, err_code 0.
- Non-memory op: accepted at edge N, wb_valid high during cycle N+1, ready_in high again at N+2. Throughput is one instruction per 2 cycles.
- Memory op: mem_req rises the cycle after acceptance. If ack arrives k cycles after req rises (k≥0, same-cycle ack allowed), wb_valid rises the cycle after that ack.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then wb_valid follows on the next cycle.
- rst during ACCESS: mem_req is low after that edge. No writeback is produced for the aborted instruction.
- rst during RESP: wb_valid is low after that edge.

## Structure
- Package mips_pkg holds:
  - state enum
  - err_code constants (ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT)
  - word width constant
- Sub-module bus_timer: a counter with clear, enable and expired output, sized $clog2(TIMEOUT+1).

## Test plan
- ALU passthrough: alu_result=0x0000_0042, wreg=3, RegWrite=1 → wb_valid one cycle later, wb_data=0x42, wb_we=1, mem_req never asserted.
- Load, 3-cycle ack: addr 0x100, mem_rdata=0xDEADBEEF, MemtoReg=1, wreg=8 → mem_req high 3 cycles at addr 0x100, wb_data=0xDEADBEEF, wb_reg=8, wb_we=1; ready_in low throughout.
- Store with same-cycle ack: addr 0x204, store_data=0x1234 → mem_we=1, mem_wdata=0x1234 for one cycle; wb_we=0 (RegWrite=0).
- Misaligned load at 0x102 → no mem_req, wb_we=0, err=1, err_code=1. Load to wreg=0 → wb_we=0, err unchanged.
- Timeout: TIMEOUT=4, no ack → mem_req high 4 cycles, then err_code=3, wb_we=0. A late ack in IDLE changes nothing.
- rst asserted mid-ACCESS → mem_req 0 next cycle, no wb_valid, err 0. The next instruction completes normally.
